// File: rtl/pixel_stream_mem_writer.sv
// pixel_stream_mem_writer
//   Avalon-MM write master. Takes a valid/ready stream of DATA_W-bit pixel
//   words and writes them, one word per transfer, to consecutive word
//   addresses starting at a latched base. A small FIFO absorbs interconnect
//   back-pressure (avm_waitrequest).
//
//   Optional feature macro: PIXW_CONTINUOUS_EN
//     When defined, a completed job restarts at the latched base/count
//     without a new start (frame ring buffer); busy stays high until reset.
//
// Ports
//   clk, reset                 single clock, synchronous active-high reset
//   start, base_addr,          job command; sampled only while idle
//   word_count
//   busy, done                 busy = not idle; done = 1-cycle completion pulse
//   sink_valid/data/ready      input pixel stream
//   avm_address/chipselect/    Avalon-MM write master (word addressed);
//   write/writedata/           all write outputs registered
//   byteenable/waitrequest
module pixel_stream_mem_writer #(
  parameter int ADDR_W     = 14,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [CNT_W-1:0]    word_count,
  output logic                busy,
  output logic                done,
  input  logic                sink_valid,
  input  logic [DATA_W-1:0]   sink_data,
  output logic                sink_ready,
  output logic [ADDR_W-1:0]   avm_address,
  output logic                avm_chipselect,
  output logic                avm_write,
  output logic [DATA_W-1:0]   avm_writedata,
  output logic [DATA_W/8-1:0] avm_byteenable,
  input  logic                avm_waitrequest
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] DEPTH_V = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t state, state_nxt;

  // FIFO holds words accepted but not yet presented on the bus. The word
  // currently on the bus lives in the avm_* registers and counts toward
  // occupancy, so at most FIFO_DEPTH words are buffered in total.
  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [PTR_W:0]    fifo_cnt;
  logic [PTR_W:0]    occ;

  logic [CNT_W-1:0]  cnt_lat;    // latched job length
  logic [CNT_W-1:0]  acc_cnt;    // beats accepted this job
  logic [CNT_W-1:0]  cmp_cnt;    // writes completed this job
  logic [ADDR_W-1:0] next_addr;  // address for the next write to present
`ifdef PIXW_CONTINUOUS_EN
  logic [ADDR_W-1:0] base_lat;
`endif

  logic start_go, push, fifo_empty, slot_free, complete;
  logic load, pop, fifo_wr, acc_last, final_cmp;

  always_comb begin
    start_go   = (state == IDLE) && start;
    occ        = fifo_cnt + {{PTR_W{1'b0}}, avm_write};
    sink_ready = (state == RUN) && (occ < DEPTH_V) && (acc_cnt < cnt_lat);
    push       = sink_valid && sink_ready;
    fifo_empty = (fifo_cnt == '0);
    complete   = avm_write && !avm_waitrequest;
    // Output stage may take a new word when idle or finishing this cycle.
    slot_free  = !avm_write || !avm_waitrequest;
    pop        = slot_free && !fifo_empty;
    // With an empty FIFO the incoming beat goes straight to the bus
    // registers, giving accept-to-write latency of one cycle.
    load       = slot_free && (!fifo_empty || push);
    fifo_wr    = push && !(slot_free && fifo_empty);
    acc_last   = push && ((acc_cnt + CNT_W'(1)) == cnt_lat);
    final_cmp  = complete && ((cmp_cnt + CNT_W'(1)) == cnt_lat);
    busy       = (state != IDLE);
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start && (word_count != '0)) state_nxt = RUN;
      RUN:   if (acc_last) state_nxt = FLUSH;
      FLUSH: begin
`ifdef PIXW_CONTINUOUS_EN
        if (final_cmp) state_nxt = RUN;
`else
        if (final_cmp) state_nxt = IDLE;
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Job counters and command capture
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_lat   <= '0;
      acc_cnt   <= '0;
      cmp_cnt   <= '0;
      next_addr <= '0;
`ifdef PIXW_CONTINUOUS_EN
      base_lat  <= '0;
`endif
    end else if (start_go) begin
      cnt_lat   <= word_count;
      acc_cnt   <= '0;
      cmp_cnt   <= '0;
      next_addr <= base_addr;
`ifdef PIXW_CONTINUOUS_EN
      base_lat  <= base_addr;
`endif
    end else begin
      if (push)     acc_cnt   <= acc_cnt + CNT_W'(1);
      if (complete) cmp_cnt   <= cmp_cnt + CNT_W'(1);
      if (load)     next_addr <= next_addr + ADDR_W'(1);  // wraps mod 2^ADDR_W
`ifdef PIXW_CONTINUOUS_EN
      // FIFO is empty and nothing loads on the final completion, so the
      // restart can simply overwrite the counters.
      if (final_cmp) begin
        acc_cnt   <= '0;
        cmp_cnt   <= '0;
        next_addr <= base_lat;
      end
`endif
    end
  end

  // done: zero-length job completes the cycle after start; otherwise the
  // cycle after the final write completes.
  always_ff @(posedge clk) begin
    if (reset) done <= 1'b0;
    else       done <= (start_go && (word_count == '0)) || final_cmp;
  end

  // FIFO storage (no reset needed; pointers define validity)
  always_ff @(posedge clk) begin
    if (fifo_wr) fifo_mem[wr_ptr] <= sink_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (fifo_wr) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      case ({fifo_wr, pop})
        2'b10:   fifo_cnt <= fifo_cnt + (PTR_W+1)'(1);
        2'b01:   fifo_cnt <= fifo_cnt - (PTR_W+1)'(1);
        default: fifo_cnt <= fifo_cnt;  // none, or simultaneous push/pop
      endcase
    end
  end

  // Bus output registers: only change when the slot is free, so address,
  // data and write hold steady through waitrequest.
  always_ff @(posedge clk) begin
    if (reset) begin
      avm_write     <= 1'b0;
      avm_address   <= '0;
      avm_writedata <= '0;
    end else if (slot_free) begin
      avm_write <= load;
      if (load) begin
        avm_address   <= next_addr;
        avm_writedata <= fifo_empty ? sink_data : fifo_mem[rd_ptr];
      end
    end
  end

  assign avm_chipselect = avm_write;
  assign avm_byteenable = '1;

endmodule

// File: tb/tb_pixel_stream_mem_writer.sv
module tb_pixel_stream_mem_writer;
  localparam int AW = 14, DW = 32, DEPTH = 8, CW = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1, start = 1'b0, busy, done;
  logic [AW-1:0] base_addr = '0;
  logic [CW-1:0] word_count = '0;
  logic sink_valid = 1'b0, sink_ready;
  logic [DW-1:0] sink_data = '0;
  logic [AW-1:0] avm_address;
  logic avm_chipselect, avm_write, avm_waitrequest = 1'b0;
  logic [DW-1:0] avm_writedata;
  logic [DW/8-1:0] avm_byteenable;

  pixel_stream_mem_writer #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .word_count(word_count),
    .busy(busy), .done(done), .sink_valid(sink_valid), .sink_data(sink_data),
    .sink_ready(sink_ready), .avm_address(avm_address), .avm_chipselect(avm_chipselect),
    .avm_write(avm_write), .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
    .avm_waitrequest(avm_waitrequest));

  int checks = 0, errors = 0, cyc = 0;

  // stimulus controls
  logic drv_reset = 1'b1, drv_start = 1'b0;
  logic [AW-1:0] drv_base = '0;
  logic [CW-1:0] drv_cnt = '0;
  int wait_pct = 0, stall_idx = -1, stall_left = 0;

  // observations
  logic [AW-1:0] wa_q[$];
  logic [DW-1:0] wd_q[$];
  int wc_q[$];
  int done_q[$];
  logic done_busy[$];
  logic [DW-1:0] exp_d[$];
  int busy_seen, rdy_idle_err, sig_err, stall_err, n_acc, max_infl;
  logic prev_stall;
  logic [AW-1:0] prev_a;
  logic [DW-1:0] prev_d;

  task automatic clear_rec();
    wa_q.delete(); wd_q.delete(); wc_q.delete(); done_q.delete(); done_busy.delete();
    busy_seen = 0; rdy_idle_err = 0; sig_err = 0; stall_err = 0; n_acc = 0; max_infl = 0;
    prev_stall = 1'b0; prev_a = '0; prev_d = '0;
  endtask

  // One clock: drive after the rising edge, observe at the falling edge.
  task automatic cycle(input logic v, input logic [DW-1:0] d, output logic acc);
    @(posedge clk); #1;
    reset = drv_reset; start = drv_start; base_addr = drv_base; word_count = drv_cnt;
    sink_valid = v; sink_data = d;
    avm_waitrequest = ($urandom_range(99) < wait_pct);
    if (avm_write && stall_idx == wa_q.size() && stall_left > 0) begin
      avm_waitrequest = 1'b1; stall_left--;
    end
    @(negedge clk); cyc++;
    acc = v && sink_ready && !drv_reset;
    if (acc) n_acc++;
    if (avm_write && !avm_waitrequest) begin
      wa_q.push_back(avm_address); wd_q.push_back(avm_writedata); wc_q.push_back(cyc);
    end
    if (done) begin done_q.push_back(cyc); done_busy.push_back(busy); end
    if (busy) busy_seen++;
    if (sink_ready && !busy) rdy_idle_err++;
    if (avm_chipselect !== avm_write || avm_byteenable !== 4'hF) sig_err++;
    if (prev_stall && (avm_write !== 1'b1 || avm_address !== prev_a || avm_writedata !== prev_d))
      stall_err++;
    prev_stall = avm_write && avm_waitrequest && !drv_reset;
    prev_a = avm_address; prev_d = avm_writedata;
    if (n_acc - wa_q.size() > max_infl) max_infl = n_acc - wa_q.size();
  endtask

  // Launch a job and feed its stream until done (bounded), plus 3 idle cycles.
  task automatic run_job(input logic [AW-1:0] base, input int n, input int vpct,
                         input bit seq, input int inject_at, output int s);
    logic acc, v;
    int idx, k;
    clear_rec();
    exp_d.delete();
    for (int i = 0; i < n; i++) exp_d.push_back(seq ? DW'(32'hA0 + i) : DW'($urandom));
    drv_base = base; drv_cnt = CW'(n); drv_start = 1'b1;
    cycle(1'b0, '0, acc);
    s = cyc; drv_start = 1'b0;
    idx = 0; k = 0;
    while (done_q.size() == 0 && k < 3000) begin
      v = (idx < n) && ($urandom_range(99) < vpct);
      if (k == inject_at) begin drv_start = 1'b1; drv_base = ~base; drv_cnt = 7; end
      else drv_start = 1'b0;
      cycle(v, v ? exp_d[idx] : DW'($urandom), acc);
      if (acc) idx++;
      k++;
    end
    drv_start = 1'b0;
    repeat (3) cycle(1'b0, '0, acc);
  endtask

  task automatic test_reset();
    logic acc;
    drv_reset = 1'b1;
    repeat (3) cycle(1'b0, '0, acc);
    checks++;
    if (busy !== 0 || done !== 0 || sink_ready !== 0) begin
      errors++; $display("FAIL reset_ctrl: busy=%b done=%b ready=%b want 000", busy, done, sink_ready);
    end
    checks++;
    if (avm_write !== 0 || avm_chipselect !== 0) begin
      errors++; $display("FAIL reset_write: write=%b cs=%b want 00", avm_write, avm_chipselect);
    end
    checks++;
    if (avm_address !== 0 || avm_writedata !== 0 || avm_byteenable !== 4'hF) begin
      errors++; $display("FAIL reset_bus: addr=%h data=%h be=%h want 0 0 f", avm_address, avm_writedata, avm_byteenable);
    end
    drv_reset = 1'b0;
    cycle(1'b0, '0, acc);
    checks++;
    if (busy !== 0 || avm_write !== 0) begin
      errors++; $display("FAIL reset_release: busy=%b write=%b want 00", busy, avm_write);
    end
  endtask

  task automatic test_basic();
    int s;
    wait_pct = 0; stall_idx = -1;
    run_job(14'h0100, 4, 100, 1'b1, -1, s);
    checks++;
    if (wa_q.size() !== 4) begin errors++; $display("FAIL basic_count: got %0d want 4", wa_q.size()); end
    for (int i = 0; i < wa_q.size(); i++) begin
      checks++;
      if (wa_q[i] !== 14'h0100 + AW'(i) || wd_q[i] !== DW'(32'hA0 + i) || wc_q[i] !== s + 2 + i) begin
        errors++;
        $display("FAIL basic_write%0d: addr=%h data=%h cyc=%0d want %h %h %0d", i, wa_q[i], wd_q[i],
                 wc_q[i] - s, 14'h0100 + AW'(i), 32'hA0 + i, 2 + i);
      end
    end
    checks++;
    if (done_q.size() !== 1 || done_q[0] !== s + 6 || done_busy[0] !== 1'b0) begin
      errors++; $display("FAIL basic_done: pulses=%0d at=%0d want 1 at %0d with busy low", done_q.size(),
                         done_q.size() ? done_q[0] - s : -1, 6);
    end
    checks++;
    if (busy !== 0 || sig_err !== 0 || rdy_idle_err !== 0) begin
      errors++; $display("FAIL basic_misc: busy=%b sig_err=%0d rdy_idle=%0d want 0", busy, sig_err, rdy_idle_err);
    end
  endtask

  task automatic test_backpressure();
    int s;
    wait_pct = 0; stall_idx = 1; stall_left = 3;
    run_job(14'h0100, 4, 100, 1'b1, -1, s);
    checks++;
    if (wa_q.size() !== 4 || wc_q[0] !== s + 2 || wc_q[1] !== s + 6 || wc_q[3] !== s + 8) begin
      errors++; $display("FAIL bp_timing: writes=%0d w1_cyc=%0d want 4 writes, w1 at %0d", wa_q.size(),
                         wa_q.size() > 1 ? wc_q[1] - s : -1, 6);
    end
    checks++;
    if (wa_q.size() > 1 && (wa_q[1] !== 14'h0101 || wd_q[1] !== 32'hA1)) begin
      errors++; $display("FAIL bp_w1: addr=%h data=%h want 0101 a1", wa_q[1], wd_q[1]);
    end
    checks++;
    if (stall_err !== 0) begin errors++; $display("FAIL bp_hold: %0d unstable stall cycles want 0", stall_err); end
    // long stall on the first write: buffering must cap at FIFO_DEPTH
    stall_idx = 0; stall_left = 20;
    run_job(14'h0200, 12, 100, 1'b0, -1, s);
    checks++;
    if (max_infl !== DEPTH) begin errors++; $display("FAIL bp_fill: buffered max %0d want %0d", max_infl, DEPTH); end
    checks++;
    if (wa_q.size() !== 12 || stall_err !== 0 || done_q.size() !== 1) begin
      errors++; $display("FAIL bp_long: writes=%0d stall_err=%0d dones=%0d want 12 0 1", wa_q.size(), stall_err, done_q.size());
    end
    for (int i = 0; i < wa_q.size(); i++) begin
      checks++;
      if (wa_q[i] !== 14'h0200 + AW'(i) || wd_q[i] !== exp_d[i]) begin
        errors++; $display("FAIL bp_long_w%0d: %h/%h want %h/%h", i, wa_q[i], wd_q[i], 14'h0200 + AW'(i), exp_d[i]);
      end
    end
    stall_idx = -1;
  endtask

  task automatic test_wrap();
    int s;
    logic [AW-1:0] ea [4];
    ea[0] = 14'h3FFE; ea[1] = 14'h3FFF; ea[2] = 14'h0000; ea[3] = 14'h0001;
    wait_pct = 30; stall_idx = -1;
    run_job(14'h3FFE, 4, 60, 1'b0, -1, s);
    checks++;
    if (wa_q.size() !== 4 || done_q.size() !== 1) begin
      errors++; $display("FAIL wrap_count: writes=%0d dones=%0d want 4 1", wa_q.size(), done_q.size());
    end
    for (int i = 0; i < wa_q.size() && i < 4; i++) begin
      checks++;
      if (wa_q[i] !== ea[i] || wd_q[i] !== exp_d[i]) begin
        errors++; $display("FAIL wrap_w%0d: %h/%h want %h/%h", i, wa_q[i], wd_q[i], ea[i], exp_d[i]);
      end
    end
    wait_pct = 0;
  endtask

  task automatic test_zero();
    logic acc;
    int s;
    clear_rec();
    drv_base = 14'h0055; drv_cnt = 0; drv_start = 1'b1;
    cycle(1'b1, '0, acc);
    s = cyc; drv_start = 1'b0;
    repeat (4) cycle(1'b1, '0, acc);
    checks++;
    if (done_q.size() !== 1 || done_q[0] !== s + 1) begin
      errors++; $display("FAIL zero_done: pulses=%0d at=%0d want 1 at 1", done_q.size(), done_q.size() ? done_q[0] - s : -1);
    end
    checks++;
    if (wa_q.size() !== 0 || busy_seen !== 0 || n_acc !== 0) begin
      errors++; $display("FAIL zero_idle: writes=%0d busy=%0d acc=%0d want 0", wa_q.size(), busy_seen, n_acc);
    end
  endtask

  task automatic test_reset_mid();
    logic acc;
    int s, idx, k;
    clear_rec();
    wait_pct = 0; stall_idx = -1;
    drv_base = 14'h0400; drv_cnt = 10; drv_start = 1'b1;
    cycle(1'b0, '0, acc);
    drv_start = 1'b0; idx = 0; k = 0;
    while (wa_q.size() < 5 && k < 100) begin cycle(1'b1, DW'(idx), acc); if (acc) idx++; k++; end
    drv_reset = 1'b1;
    cycle(1'b1, DW'(idx), acc);
    drv_reset = 1'b0;
    cycle(1'b0, '0, acc);
    checks++;
    if (busy !== 0 || done !== 0 || sink_ready !== 0 || avm_write !== 0 || avm_chipselect !== 0 ||
        avm_address !== 0 || avm_writedata !== 0) begin
      errors++; $display("FAIL rstmid_outputs: busy=%b done=%b rdy=%b wr=%b addr=%h data=%h want all 0",
                         busy, done, sink_ready, avm_write, avm_address, avm_writedata);
    end
    repeat (6) cycle(1'b1, '0, acc);
    checks++;
    if (done_q.size() !== 0 || avm_write !== 0) begin
      errors++; $display("FAIL rstmid_nodone: dones=%0d write=%b want 0 0", done_q.size(), avm_write);
    end
    run_job(14'h0A00, 6, 100, 1'b0, -1, s);
    checks++;
    if (wa_q.size() !== 6 || done_q.size() !== 1) begin
      errors++; $display("FAIL rstmid_rerun: writes=%0d dones=%0d want 6 1", wa_q.size(), done_q.size());
    end
    for (int i = 0; i < wa_q.size(); i++) begin
      checks++;
      if (wa_q[i] !== 14'h0A00 + AW'(i) || wd_q[i] !== exp_d[i]) begin
        errors++; $display("FAIL rstmid_w%0d: %h/%h want %h/%h", i, wa_q[i], wd_q[i], 14'h0A00 + AW'(i), exp_d[i]);
      end
    end
  endtask

  task automatic test_random_jobs();
    int s, n, inj;
    logic [AW-1:0] b;
    for (int j = 0; j < 6; j++) begin
      b = AW'($urandom);
      n = (j == 2) ? 10 : int'($urandom_range(24, 1));
      inj = (j == 2) ? 3 : -1;  // a start while busy must be ignored
      wait_pct = int'($urandom_range(60));
      run_job(b, n, int'($urandom_range(100, 30)), 1'b0, inj, s);
      checks++;
      if (wa_q.size() !== n || done_q.size() !== 1) begin
        errors++; $display("FAIL rand%0d_count: writes=%0d dones=%0d want %0d 1", j, wa_q.size(), done_q.size(), n);
      end
      for (int i = 0; i < wa_q.size() && i < n; i++) begin
        checks++;
        if (wa_q[i] !== b + AW'(i) || wd_q[i] !== exp_d[i]) begin
          errors++; $display("FAIL rand%0d_w%0d: %h/%h want %h/%h", j, i, wa_q[i], wd_q[i], b + AW'(i), exp_d[i]);
        end
      end
      checks++;
      if (wc_q.size() > 0 && done_q.size() > 0 && (done_q[0] !== wc_q[wc_q.size()-1] + 1 || done_busy[0] !== 1'b0)) begin
        errors++; $display("FAIL rand%0d_done: at %0d want %0d", j, done_q[0], wc_q[wc_q.size()-1] + 1);
      end
      checks++;
      if (stall_err !== 0 || sig_err !== 0 || rdy_idle_err !== 0 || max_infl > DEPTH) begin
        errors++; $display("FAIL rand%0d_proto: stall=%0d sig=%0d rdy_idle=%0d buf=%0d want 0 0 0 <=%0d",
                           j, stall_err, sig_err, rdy_idle_err, max_infl, DEPTH);
      end
    end
    wait_pct = 0;
  endtask

  task automatic test_continuous();
    logic acc;
    logic [AW-1:0] b;
    int i, nd;
    clear_rec();
    wait_pct = 0; stall_idx = -1;
    b = AW'($urandom);
    drv_base = b; drv_cnt = 2; drv_start = 1'b1;
    cycle(1'b0, '0, acc);
    drv_start = 1'b0; i = 0;
    repeat (40) begin cycle(1'b1, DW'(32'h100 + i), acc); if (acc) i++; end
    checks++;
    if (wa_q.size() < 6) begin errors++; $display("FAIL cont_count: writes=%0d want >=6", wa_q.size()); end
    for (int j = 0; j < wa_q.size(); j++) begin
      checks++;
      if (wa_q[j] !== b + AW'(j % 2) || wd_q[j] !== DW'(32'h100 + j)) begin
        errors++; $display("FAIL cont_w%0d: %h/%h want %h/%h", j, wa_q[j], wd_q[j], b + AW'(j % 2), 32'h100 + j);
      end
    end
    nd = 0;
    for (int j = 1; j < wc_q.size(); j += 2) if (wc_q[j] + 1 <= cyc) nd++;
    checks++;
    if (done_q.size() !== nd) begin errors++; $display("FAIL cont_dones: got %0d want %0d", done_q.size(), nd); end
    for (int k = 0; k < done_q.size() && 2*k+1 < wc_q.size(); k++) begin
      checks++;
      if (done_q[k] !== wc_q[2*k+1] + 1) begin
        errors++; $display("FAIL cont_done%0d: at %0d want %0d", k, done_q[k], wc_q[2*k+1] + 1);
      end
    end
    checks++;
    if (busy_seen !== 40) begin errors++; $display("FAIL cont_busy: busy cycles %0d want 40", busy_seen); end
  endtask

  initial begin
    clear_rec();
    test_reset();
`ifdef PIXW_CONTINUOUS_EN
    test_continuous();
`else
    test_basic();
    test_backpressure();
    test_wrap();
    test_zero();
    test_reset_mid();
    test_random_jobs();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pixel_stream_mem_writer.md
# pixel_stream_mem_writer

Avalon-MM write master that takes a valid/ready stream of 32-bit pixel words from the camera pipeline and stores them, one word per transfer, into consecutive word addresses of an on-chip memory slave. A small internal FIFO decouples the stream from interconnect back-pressure (`avm_waitrequest`). It sits between the vision pipeline output and the Qsys on-chip memory, and is controlled by a start/base/count command from the Nios-side control logic.

## Interface

- `ADDR_W`, default 14: word-address width; matches the 14-bit memory slave address.
- `DATA_W`, default 32: data width; the byte-enable width is `DATA_W/8`.
- `FIFO_DEPTH`, default 8: internal FIFO depth in words; must be a power of two and at least 2.
- `CNT_W`, default 15: width of `word_count`.

Ports:

- `clk` input 1: single clock for all logic.
- `reset` input 1: synchronous, active-high reset.
- `start` input 1: one-cycle command pulse; sampled only in IDLE.
- `base_addr` input ADDR_W: first word address; captured on `start`.
- `word_count` input CNT_W: number of words to write; captured on `start`.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle pulse when a job completes.
- `sink_valid` input 1: a stream word is present.
- `sink_data` input DATA_W: the stream word.
- `sink_ready` output 1: the block can accept a word this cycle.
- `avm_address` output ADDR_W: word address of the write.
- `avm_chipselect` output 1: equal to `avm_write`.
- `avm_write` output 1: write request.
- `avm_writedata` output DATA_W: write data.
- `avm_byteenable` output DATA_W/8: constant all-ones.
- `avm_waitrequest` input 1: interconnect stall.

## Operation

- **States:** IDLE, RUN, FLUSH.
- **IDLE:**
  - On `start`, latch `base_addr` and `word_count`, and clear the accept counter and issue counter.
  - If `word_count`==0, stay in IDLE and pulse `done` on the next cycle; no write is issued.
  - Otherwise go to RUN.
- **RUN:**
  - `sink_ready` = FIFO not full AND accept counter < latched count.
  - A beat is accepted when `sink_valid` and `sink_ready` are both high; it is pushed to the FIFO and the accept counter increments.
  - When the accept counter reaches the count, go to FLUSH.
- **Write side (active in RUN and FLUSH):**
  - When the FIFO is non-empty and no write is outstanding, present the FIFO head with `avm_write`=1.
  - Address = (latched base + issue counter) mod 2^ADDR_W; addresses wrap past the top with no error.
  - A write completes on a cycle where `avm_write`=1 and `avm_waitrequest`=0; the FIFO pops and the issue counter increments.
- **FLUSH:**
  - `sink_ready`=0.
  - When the final write completes, return to IDLE and pulse `done` one cycle later.
- **Simultaneous push and pop** on a full or empty FIFO are both legal; occupancy is unchanged by a simultaneous push and pop.
- **`start` while `busy`** is ignored.
- **Stream beats in IDLE** are not accepted (`sink_ready`=0).

## Timing

- **Reset values:**
  - `busy`, `done`, `sink_ready`, `avm_write`, `avm_chipselect` = 0.
  - `avm_address`, `avm_writedata` = 0.
  - `avm_byteenable` = all-ones.
  - FIFO and counters are cleared.
- **Earliest latency:**
  - `sink_ready` rises the cycle after `start`.
  - A beat accepted in cycle N drives `avm_write` in cycle N+1.
- **Stall rule:** while `avm_waitrequest`=1, `avm_address`, `avm_writedata` and `avm_write` are held stable. All write outputs are registered.
- **Throughput:** one write per cycle when `avm_waitrequest`=0 and the stream is continuous.
- **`done` timing:** pulse is exactly one cycle, in the cycle after the final write completes.
- **Reset mid-job:** the in-flight write is abandoned (`avm_write` drops the next cycle), FIFO contents are discarded, and no `done` pulse is issued.

## Configuration

- **`PIXW_CONTINUOUS_EN` defined:**
  - After the final write of a job completes, the block pulses `done` and restarts RUN at the latched base with the latched count, without a new `start`. This gives a frame ring buffer.
  - `busy` stays 1 until `reset`.
- **`PIXW_CONTINUOUS_EN` undefined:** single-shot behaviour exactly as described under Operation.

## Test plan

- **Basic job:** `base_addr`=0x0100, `word_count`=4, data 0xA0..0xA3 streamed back-to-back, `avm_waitrequest`=0 -> writes to 0x0100..0x0103 on 4 consecutive cycles; `done` pulses 1 cycle after the last write; `busy` then falls.
- **Back-pressure:** the same job with `avm_waitrequest` high for 3 cycles on the second write -> address 0x0101 and data 0xA1 held stable for 4 cycles; `sink_ready` drops once 8 words are buffered.
- **Address wrap:** `base_addr`=0x3FFE, `word_count`=4 -> writes to 0x3FFE, 0x3FFF, 0x0000, 0x0001.
- **Zero count:** `word_count`=0 -> no `avm_write`; `done` pulses the cycle after `start`; `busy` never asserts.
- **Reset mid-job:** `word_count`=10 with `reset` after 5 writes -> all outputs return to reset values the next cycle; no `done`; a new `start` then runs cleanly from its base.
- **Continuous mode (`PIXW_CONTINUOUS_EN`):** `word_count`=2 -> `done` pulses every 2 writes and addresses repeat base, base+1.
